// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : shared constants for the prefetching fetch queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int          FQ_DEPTH        = 4;
    localparam int          FQ_ADDR_SIZE    = 32;
    localparam int          FQ_INSTR_SIZE   = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_sync_fifo_clr.sv
// ============================================================================
// sync_fifo_clr : circular-buffer FIFO with synchronous clear and async reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_clr #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full_o    = (count_q == c_DEPTH);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign w_do_wr   = wr_en_i & ~full_o;
    assign w_do_rd   = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths correct.
            if (w_do_wr) begin
                wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, w_do_wr} - {{(CW-1){1'b0}}, w_do_rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : credit-limited instruction prefetch queue with redirect flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                    ADDR_SIZE  = FQ_ADDR_SIZE,
    parameter int                    INSTR_SIZE = FQ_INSTR_SIZE,
    parameter int                    DEPTH      = FQ_DEPTH,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_SIZE-1:0]   imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_SIZE-1:0]  imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_SIZE-1:0]   redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_SIZE-1:0]  instr,
    output logic [ADDR_SIZE-1:0]   instr_pc,
    output logic [ADDR_SIZE-1:0]   instr_pcplus4,
    input  logic                   instr_ready
);

    localparam int                   CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]          c_LIMIT = (CW+1)'(DEPTH);
    localparam logic [ADDR_SIZE-1:0] c_FOUR  = ADDR_SIZE'(4);

    logic [ADDR_SIZE-1:0]            fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0]            resp_pc_q, resp_pc_d;
    logic [CW-1:0]                   outstanding_q, outstanding_d;
    logic [CW-1:0]                   discard_q, discard_d;
    logic [CW-1:0]                   w_occ;
    logic [CW:0]                     w_credit_used;
    logic [ADDR_SIZE-1:0]            w_target;
    logic                            w_accept, w_keep, w_drop, w_enq, w_deq;
    logic                            w_full, w_empty;
    logic [INSTR_SIZE+ADDR_SIZE-1:0] w_head;

    assign w_target      = redirect_pc & ~ADDR_SIZE'(3);
    assign w_credit_used = {1'b0, w_occ} + {1'b0, outstanding_q};
    assign imem_req      = ~reset & ~redirect & (w_credit_used < c_LIMIT);
    assign imem_addr     = fetch_pc_q;
    assign w_accept      = imem_req & imem_ready;
    assign w_keep        = imem_rvalid & (discard_q == '0);
    assign w_drop        = imem_rvalid & (discard_q != '0);
    assign w_enq         = w_keep & ~w_full;
    assign w_deq         = instr_valid & instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + {{(CW-1){1'b0}}, w_accept}
                                      - {{(CW-1){1'b0}}, imem_rvalid};
        discard_d     = discard_q - {{(CW-1){1'b0}}, w_drop};
        if (redirect) begin
            // Whatever is still in flight after this edge belongs to the old path.
            fetch_pc_d = w_target;
            resp_pc_d  = w_target;
            discard_d  = outstanding_q - {{(CW-1){1'b0}}, imem_rvalid};
        end else begin
            if (w_accept) fetch_pc_d = fetch_pc_q + c_FOUR;
            if (w_keep)   resp_pc_d  = resp_pc_q + c_FOUR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo_clr #(
        .WIDTH (INSTR_SIZE + ADDR_SIZE),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (redirect),
        .wr_en_i   (w_enq),
        .wr_data_i ({imem_rdata, resp_pc_q}),
        .rd_en_i   (w_deq),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_occ)
    );

    assign instr_valid   = ~w_empty;
    assign instr         = instr_valid ? w_head[INSTR_SIZE+ADDR_SIZE-1:ADDR_SIZE]
                                       : INSTR_SIZE'(NOP_INSTR);
    assign instr_pc      = instr_valid ? w_head[ADDR_SIZE-1:0] : '0;
    assign instr_pcplus4 = instr_valid ? w_head[ADDR_SIZE-1:0] + c_FOUR : '0;

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch path of the xgriscv pipeline.
- Decouples instruction memory from decode with a DEPTH-entry prefetch queue and credit-limited outstanding requests.
- Supports a decode-side stall (ready) and a branch/jump redirect that flushes both the queue and any in-flight responses.
- Sits between the instruction memory and the IF/ID boundary. It replaces the PC register, the PC+4 adder and the fetch pipeline register.

Parameters:
- ADDR_SIZE, 32, PC/address width.
- INSTR_SIZE, 32, instruction width.
- DEPTH, 4, queue entries; also the maximum number of outstanding requests (range 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_SIZE  request word address, bits[1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid. Responses return in order with latency ≥1 cycle.
- imem_rdata  in  INSTR_SIZE  response instruction.
- redirect  in  1  control transfer taken this cycle.
- redirect_pc  in  ADDR_SIZE  new fetch PC. Bits[1:0] are ignored and forced to 0.
- instr_valid  out  1  queue head valid.
- instr  out  INSTR_SIZE  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
- instr_pc  out  ADDR_SIZE  PC of the head instruction.
- instr_pcplus4  out  ADDR_SIZE  instr_pc+4, wraps modulo 2^ADDR_SIZE.
- instr_ready  in  1  decode consumes the head; dequeue when instr_valid & instr_ready.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, using ports clk and reset.
- Reset values:
  - fetch PC = RESET_PC; queue empty; outstanding=0; discard=0.
  - imem_req=0, instr_valid=0, instr=NOP, instr_pc=0, instr_pcplus4=0.
- Issue rule:
  - imem_req = ~reset & ~redirect & (occupancy + outstanding < DEPTH).
  - imem_addr = fetch PC.
  - On imem_req & imem_ready: fetch PC += 4 (modulo wrap) and outstanding increments.
- Credit rule: the queue can never overflow. An enqueue while full is a design error; the bench asserts it never happens.
- Response path:
  - If imem_rvalid & discard>0: drop the response and decrement discard.
  - Otherwise enqueue {imem_rdata, PC}, where PC comes from a parallel response-PC register that advances by 4 per kept response.
  - Every rvalid decrements outstanding.
- Queue timing:
  - Registered, with no bypass. An enqueue in cycle N is visible at the head in N+1.
  - Best-case latency from request accepted to instr_valid, with 1-cycle memory: 2 cycles.
- Simultaneous enqueue and dequeue: occupancy unchanged; both take effect.
- Redirect, in the cycle redirect=1:
  - Queue cleared at the clock edge; any dequeue that cycle is ignored.
  - fetch PC and response PC both load {redirect_pc[ADDR_SIZE-1:2], 2'b00}.
  - discard <= outstanding − (imem_rvalid & discard==0 ? 1 : 0) − (imem_rvalid & discard>0 ? 1 : 0). The net effect is that every old-path response still in flight after this edge is dropped.
  - imem_req is forced to 0 that cycle. The first new-path request can issue the next cycle.
- Back-to-back redirects: each one recomputes discard from the current outstanding. The last redirect wins.
- Stall: while instr_ready=0, the head is held stable and issue continues until the credit limit is reached.
- Redirect with reset asserted: reset dominates.
- Counter widths: occupancy, outstanding and discard are each $clog2(DEPTH+1) bits. They are never negative; the bench checks this.

Decomposition:
- Add to xgriscv_defines.v: `NOP_INSTR 32'h00000013, `FQ_DEPTH default; reuse `ADDR_SIZE and `INSTR_SIZE.
- Sub-module sync_fifo_clr (parameters WIDTH, DEPTH):
  - Circular buffer with wrap-around pointers.
  - Synchronous clear input, async reset, full/empty/count outputs.
  - Instantiated once with WIDTH = INSTR_SIZE + ADDR_SIZE.
- Credit, discard and PC logic stay in fetch_queue.

Test Plan:
- Reset release, 1-cycle memory, instr_ready=1:
  - imem_addr sequence 0,4,8,… on consecutive cycles.
  - instr_valid first high 2 cycles after the first accept, with instr_pc=0 and instr_pcplus4=4.
- instr_ready=0 for 10 cycles with DEPTH=4:
  - Exactly 4 requests accepted, then imem_req=0.
  - Head stays at pc=0.
  - Releasing ready drains pcs 0,4,8,12 in order.
- 3-cycle memory latency, redirect to 0x100 while 2 requests are outstanding:
  - The two old responses are dropped.
  - The next instr_valid shows pc=0x100.
  - No old-path pc ever appears at the head.
- redirect_pc=0x203: the fetch restarts at 0x200.
- Redirect asserted in the same cycle as imem_rvalid and a dequeue:
  - Queue empty the next cycle; discard = outstanding−1.
  - First valid pc = redirect target.
- fetch PC 0xFFFF_FFFC: the next address wraps to 0x0000_0000 and instr_pcplus4 = 0.
- Assert reset mid-stream with a full queue:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - Fetch resumes at RESET_PC after release.
